// File: rtl/round_robin_dispatcher.sv
// round_robin_dispatcher: fans one valid/ready stream out across NumOut lanes in strict round-robin order.
// Optional lane eligibility mask enabled by defining ROUND_ROBIN_DISPATCHER_MASK_EN.
`default_nettype none

module round_robin_dispatcher #(
  parameter  int Clog2NumOut = 2,
  parameter  int DataWidth   = 8,
  localparam int NumOut      = 2 ** Clog2NumOut
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic                   en_i,
`ifdef ROUND_ROBIN_DISPATCHER_MASK_EN
  input  logic [NumOut-1:0]      lane_mask_i,
`endif
  input  logic [DataWidth-1:0]   data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [DataWidth-1:0]   data_o,
  output logic [NumOut-1:0]      valid_o,
  input  logic [NumOut-1:0]      ready_i,
  output logic [Clog2NumOut-1:0] lane_o
);

  logic                   full;
  logic [DataWidth-1:0]   data_q;
  logic [Clog2NumOut-1:0] lane_q;
  logic [Clog2NumOut-1:0] ptr;

  logic                   drain;
  logic                   cap;
  logic                   any_eligible;
  logic [Clog2NumOut-1:0] cap_lane;

`ifdef ROUND_ROBIN_DISPATCHER_MASK_EN
  logic [Clog2NumOut-1:0] idx;

  // Cyclic search for the first eligible lane starting at ptr.
  always_comb begin
    cap_lane     = ptr;
    any_eligible = 1'b0;
    idx          = ptr;
    for (int i = 0; i < NumOut; i++) begin
      idx = ptr + Clog2NumOut'(i);
      if (!any_eligible && lane_mask_i[idx]) begin
        any_eligible = 1'b1;
        cap_lane     = idx;
      end
    end
  end
`else
  assign cap_lane     = ptr;
  assign any_eligible = 1'b1;
`endif

  assign drain   = full & ready_i[lane_q];
  assign ready_o = en_i & any_eligible & (~full | drain);
  assign cap     = valid_i & ready_o;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      full   <= 1'b0;
      data_q <= '0;
      lane_q <= '0;
      ptr    <= '0;
    end else if (cap) begin
      full   <= 1'b1;
      data_q <= data_i;
      lane_q <= cap_lane;
      ptr    <= cap_lane + 1'b1;
    end else if (drain) begin
      full   <= 1'b0;
    end
  end

  assign valid_o = full ? (NumOut'(1) << lane_q) : '0;
  assign data_o  = data_q;
  assign lane_o  = lane_q;

endmodule

`default_nettype wire
